// File: rtl/action_uart_tx.sv
// action_uart_tx: one-hot cart action to ASCII digit UART 8N1 transmitter with optional LF frame
module action_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit SEND_NEWLINE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] action,
  input  logic       action_valid,
  output logic       ready,
  output logic       tx,
  output logic       done,
  output logic       reject
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LF_START, LF_DATA, LF_STOP} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_i, bit_n;
  logic [7:0] sh, sh_n, code;
  logic tx_n, done_n, reject_n, tick;
  // action decode; zero marks an unmapped code
  always_comb code = action == 4'b0001 ? 8'h31 :
                     action == 4'b0100 ? 8'h32 :
                     action == 4'b1000 ? 8'h33 :
                     action == 4'b0010 ? 8'h34 : 8'h00;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign ready = st == IDLE;
  // next state, counters, shifter and the registered tx level derived from the next state
  always_comb begin
    st_n = st;
    cnt_n = (st == IDLE || tick) ? '0 : cnt + CW'(1);
    bit_n = bit_i;
    sh_n = sh;
    done_n = 1'b0;
    reject_n = 1'b0;
    case (st)
      IDLE: if (action_valid) begin
        if (code != 8'h00) begin
          st_n = START;
          sh_n = code;
        end else reject_n = 1'b1;
      end
      START, LF_START: if (tick) begin
        st_n = st == START ? DATA : LF_DATA;
        bit_n = 3'd0;
      end
      DATA, LF_DATA: if (tick) begin
        sh_n = sh >> 1;
        bit_n = bit_i + 3'd1;
        st_n = bit_i != 3'd7 ? st : st == DATA ? STOP : LF_STOP;
      end
      STOP: if (tick) begin
        st_n = SEND_NEWLINE ? LF_START : IDLE;
        sh_n = SEND_NEWLINE ? 8'h0A : sh;
        done_n = !SEND_NEWLINE;
      end
      LF_STOP: if (tick) begin
        st_n = IDLE;
        done_n = 1'b1;
      end
      default: st_n = IDLE;
    endcase
    tx_n = (st_n == START || st_n == LF_START) ? 1'b0 :
           (st_n == DATA || st_n == LF_DATA) ? sh_n[0] : 1'b1;
  end
  // state and output registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      bit_i <= 3'd0;
      sh <= 8'h00;
      tx <= 1'b1;
      done <= 1'b0;
      reject <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      bit_i <= bit_n;
      sh <= sh_n;
      tx <= tx_n;
      done <= done_n;
      reject <= reject_n;
    end
  end
endmodule
